// File: rtl/cpu.sv
// Minimal 6502-subset CPU core: ADC/SBC in several addressing modes plus flag,
// increment/decrement and transfer instructions, read-only memory bus.
// Optional feature macro: CPU_PAGE_PENALTY_EN. When defined, indexed modes take
// their extra cycle only on a page cross. Otherwise the extra cycle is always taken.
//
// cycle | meaning
// CYC_0 | opcode fetch at PC
// CYC_1 | first operand byte, or execute for implied/immediate
// CYC_2 | second operand / zero-page pointer read / index add
// CYC_3 | pointer byte read or effective-address read
// CYC_4 | pointer high read or page-fix / effective read
// CYC_5 | final effective read for the longest modes
module cpu #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [7:0]  Data_bus,
    output logic [15:0] Addr_bus,
    output logic [7:0]  IR_dbg,
    output logic [7:0]  AC_dbg,
    output logic [7:0]  X_dbg,
    output logic [7:0]  Y_dbg,
    output logic [7:0]  P_dbg,
    output logic [15:0] PC_dbg,
    output logic [2:0]  cycle_dbg
);

    typedef enum logic [2:0] {
        CYC_0 = 3'd0, CYC_1 = 3'd1, CYC_2 = 3'd2,
        CYC_3 = 3'd3, CYC_4 = 3'd4, CYC_5 = 3'd5
    } cyc_e;

    typedef enum logic [3:0] {
        M_IMP, M_IMM, M_ZP, M_ZPX, M_ABS, M_ABX, M_ABY, M_IZX, M_IZY
    } mode_e;

`ifdef CPU_PAGE_PENALTY_EN
    localparam bit PAGE_PENALTY = 1'b1;
`else
    localparam bit PAGE_PENALTY = 1'b0;
`endif

    cyc_e        cyc_q, cyc_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
    logic [7:0]  ptr_q, ptr_d, adl_q, adl_d, adh_q, adh_d;
    logic        cross_q, cross_d;

    mode_e       mode;
    logic [7:0]  idx;
    logic [8:0]  idx_sum;
    logic        exec;
    cyc_e        fix_cyc;
    logic [7:0]  opnd;
    logic [8:0]  sum;
    logic [7:0]  nz_val;
    logic        nz_upd;

    // Decode addressing mode from the latched opcode; unknown opcodes behave as implied NOPs.
    always_comb begin
        mode = M_IMP;
        case (ir_q)
            8'h69, 8'hE9: mode = M_IMM;
            8'h65:        mode = M_ZP;
            8'h75:        mode = M_ZPX;
            8'h6D:        mode = M_ABS;
            8'h7D:        mode = M_ABX;
            8'h79:        mode = M_ABY;
            8'h61:        mode = M_IZX;
            8'h71:        mode = M_IZY;
            default:      mode = M_IMP;
        endcase
    end

    // Cycle sequencer: bus address, operand/pointer capture and next cycle.
    always_comb begin
        cyc_d    = cyc_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ptr_d    = ptr_q;
        adl_d    = adl_q;
        adh_d    = adh_q;
        cross_d  = cross_q;
        Addr_bus = pc_q;
        exec     = 1'b0;
        idx      = (mode == M_ABX) ? x_q : ((mode == M_ABY) ? y_q : 8'h00);
        idx_sum  = {1'b0, adl_q} + {1'b0, idx};
        fix_cyc  = (mode == M_IZY) ? CYC_4 : CYC_3;

        if (cyc_q == CYC_0) begin
            ir_d  = Data_bus;
            pc_d  = pc_q + 16'd1;
            cyc_d = CYC_1;
        end else if (cyc_q == CYC_1) begin
            case (mode)
                M_IMP: exec = 1'b1;
                M_IMM: begin
                    exec = 1'b1;
                    pc_d = pc_q + 16'd1;
                end
                default: begin
                    adl_d = Data_bus;
                    ptr_d = Data_bus;
                    pc_d  = pc_q + 16'd1;
                    cyc_d = CYC_2;
                end
            endcase
        end else begin
            case (mode)
                M_ZP: begin
                    Addr_bus = {8'h00, adl_q};
                    exec     = 1'b1;
                end
                M_ZPX: begin
                    Addr_bus = {8'h00, adl_q};
                    if (cyc_q == CYC_2) begin
                        adl_d = adl_q + x_q;
                        cyc_d = CYC_3;
                    end else begin
                        exec = 1'b1;
                    end
                end
                M_IZX: begin
                    case (cyc_q)
                        CYC_2: begin
                            Addr_bus = {8'h00, ptr_q};
                            ptr_d    = ptr_q + x_q;
                            cyc_d    = CYC_3;
                        end
                        CYC_3: begin
                            Addr_bus = {8'h00, ptr_q};
                            adl_d    = Data_bus;
                            cyc_d    = CYC_4;
                        end
                        CYC_4: begin
                            Addr_bus = {8'h00, ptr_q + 8'd1};
                            adh_d    = Data_bus;
                            cyc_d    = CYC_5;
                        end
                        default: begin
                            Addr_bus = {adh_q, adl_q};
                            exec     = 1'b1;
                        end
                    endcase
                end
                default: begin
                    // Absolute, absolute-indexed and (zp),Y share the page-fix tail.
                    if (cyc_q == CYC_2 && mode == M_IZY) begin
                        Addr_bus         = {8'h00, ptr_q};
                        {cross_d, adl_d} = {1'b0, Data_bus} + {1'b0, y_q};
                        cyc_d            = CYC_3;
                    end else if (cyc_q == CYC_3 && mode == M_IZY) begin
                        Addr_bus = {8'h00, ptr_q + 8'd1};
                        adh_d    = Data_bus;
                        cyc_d    = CYC_4;
                    end else if (cyc_q == CYC_2) begin
                        adh_d            = Data_bus;
                        pc_d             = pc_q + 16'd1;
                        {cross_d, adl_d} = idx_sum;
                        cyc_d            = CYC_3;
                    end else if (cyc_q == fix_cyc) begin
                        Addr_bus = {adh_q, adl_q};
                        if (mode == M_ABS || (PAGE_PENALTY && !cross_q)) begin
                            exec = 1'b1;
                        end else begin
                            adh_d = adh_q + {7'd0, cross_q};
                            cyc_d = cyc_e'(cyc_q + 3'd1);
                        end
                    end else begin
                        Addr_bus = {adh_q, adl_q};
                        exec     = 1'b1;
                    end
                end
            endcase
        end
        if (exec) begin
            cyc_d = CYC_0;
        end
    end

    // Execute: ALU for ADC/SBC (SBC adds the inverted operand) and implied register ops.
    always_comb begin
        a_d    = a_q;
        x_d    = x_q;
        y_d    = y_q;
        p_d    = p_q;
        opnd   = (ir_q == 8'hE9) ? ~Data_bus : Data_bus;
        sum    = {1'b0, a_q} + {1'b0, opnd} + {8'h00, p_q[0]};
        nz_val = 8'h00;
        nz_upd = 1'b0;
        if (exec) begin
            if (mode != M_IMP) begin
                a_d    = sum[7:0];
                p_d[0] = sum[8];
                p_d[6] = (a_q[7] == opnd[7]) && (sum[7] != a_q[7]);
                nz_val = sum[7:0];
                nz_upd = 1'b1;
            end else begin
                case (ir_q)
                    8'h38: p_d[0] = 1'b1;
                    8'h18: p_d[0] = 1'b0;
                    8'hE8: begin x_d = x_q + 8'd1; nz_val = x_d; nz_upd = 1'b1; end
                    8'hC8: begin y_d = y_q + 8'd1; nz_val = y_d; nz_upd = 1'b1; end
                    8'hCA: begin x_d = x_q - 8'd1; nz_val = x_d; nz_upd = 1'b1; end
                    8'h88: begin y_d = y_q - 8'd1; nz_val = y_d; nz_upd = 1'b1; end
                    8'hAA: begin x_d = a_q; nz_val = a_q; nz_upd = 1'b1; end
                    8'h8A: begin a_d = x_q; nz_val = x_q; nz_upd = 1'b1; end
                    8'hA8: begin y_d = a_q; nz_val = a_q; nz_upd = 1'b1; end
                    8'h98: begin a_d = y_q; nz_val = y_q; nz_upd = 1'b1; end
                    default: ;
                endcase
            end
            if (nz_upd) begin
                p_d[7] = nz_val[7];
                p_d[1] = (nz_val == 8'h00);
            end
        end
    end

    // Architectural and sequencing registers with synchronous reset.
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            cyc_q   <= CYC_0;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            a_q     <= 8'h00;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            p_q     <= 8'h20;
            ptr_q   <= 8'h00;
            adl_q   <= 8'h00;
            adh_q   <= 8'h00;
            cross_q <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            ptr_q   <= ptr_d;
            adl_q   <= adl_d;
            adh_q   <= adh_d;
            cross_q <= cross_d;
        end
    end

    assign IR_dbg    = ir_q;
    assign AC_dbg    = a_q;
    assign X_dbg     = x_q;
    assign Y_dbg     = y_q;
    assign P_dbg     = p_q | 8'h20;
    assign PC_dbg    = pc_q;
    assign cycle_dbg = cyc_q;

endmodule

// File: tb/tb_cpu.sv
// Testbench for cpu: directed scenarios plus random instruction streams checked
// against an instruction-level model of the architectural state.
module tb_cpu;

`ifdef CPU_PAGE_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk_ph1 = 1'b0;
    logic        rst;
    logic [7:0]  Data_bus;
    logic [15:0] Addr_bus;
    logic [7:0]  IR_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg;
    logic [15:0] PC_dbg;
    logic [2:0]  cycle_dbg;

    logic [7:0]  mem [0:65535];
    assign Data_bus = mem[Addr_bus];

    cpu dut (
        .clk_ph1  (clk_ph1),
        .rst      (rst),
        .Data_bus (Data_bus),
        .Addr_bus (Addr_bus),
        .IR_dbg   (IR_dbg),
        .AC_dbg   (AC_dbg),
        .X_dbg    (X_dbg),
        .Y_dbg    (Y_dbg),
        .P_dbg    (P_dbg),
        .PC_dbg   (PC_dbg),
        .cycle_dbg(cycle_dbg)
    );

    always #5 clk_ph1 = ~clk_ph1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_a, m_x, m_y, m_p;
    logic [15:0] m_pc;
    logic [15:0] last_addr_g;
    int          last_cyc_g;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 8'h20; m_pc = 16'h0000;
    endtask

    task automatic set_nz(input logic [7:0] v);
        m_p[7] = v[7];
        m_p[1] = (v == 8'h00);
    endtask

    // Executes the instruction at m_pc on the model; returns cycle count and operand address.
    task automatic model_step(output int cyc, output logic [15:0] ea, output bit has_ea);
        logic [7:0]  op, b1, b2, m, zp, zp1;
        logic [15:0] base;
        int          len, c, sum, sres;
        op = mem[m_pc]; b1 = mem[m_pc + 16'd1]; b2 = mem[m_pc + 16'd2];
        cyc = 2; len = 1; has_ea = 1'b0; ea = 16'h0000; base = 16'h0000;
        case (op)
            8'h69, 8'hE9: begin len = 2; ea = m_pc + 16'd1; has_ea = 1'b1; end
            8'h65: begin len = 2; cyc = 3; ea = {8'h00, b1}; has_ea = 1'b1; end
            8'h75: begin len = 2; cyc = 4; zp = b1 + m_x; ea = {8'h00, zp}; has_ea = 1'b1; end
            8'h6D: begin len = 3; cyc = 4; ea = {b2, b1}; has_ea = 1'b1; end
            8'h7D, 8'h79: begin
                len = 3; base = {b2, b1};
                ea = base + {8'h00, (op == 8'h7D) ? m_x : m_y};
                cyc = PEN ? (4 + int'(ea[15:8] != base[15:8])) : 5;
                has_ea = 1'b1;
            end
            8'h61: begin
                len = 2; cyc = 6; zp = b1 + m_x; zp1 = zp + 8'd1;
                ea = {mem[{8'h00, zp1}], mem[{8'h00, zp}]}; has_ea = 1'b1;
            end
            8'h71: begin
                len = 2; zp1 = b1 + 8'd1;
                base = {mem[{8'h00, zp1}], mem[{8'h00, b1}]};
                ea = base + {8'h00, m_y};
                cyc = PEN ? (5 + int'(ea[15:8] != base[15:8])) : 6;
                has_ea = 1'b1;
            end
            default: ;
        endcase
        if (has_ea) begin
            m = mem[ea];
            c = int'(m_p[0]);
            if (op == 8'hE9) begin
                sum  = int'(m_a) - int'(m) - (1 - c);
                sres = int'($signed(m_a)) - int'($signed(m)) - (1 - c);
                m_p[0] = (sum >= 0);
            end else begin
                sum  = int'(m_a) + int'(m) + c;
                sres = int'($signed(m_a)) + int'($signed(m)) + c;
                m_p[0] = (sum > 255);
            end
            m_a = 8'(sum);
            m_p[6] = (sres > 127) || (sres < -128);
            set_nz(m_a);
        end else begin
            case (op)
                8'h38: m_p[0] = 1'b1;
                8'h18: m_p[0] = 1'b0;
                8'hE8: begin m_x = m_x + 8'd1; set_nz(m_x); end
                8'hC8: begin m_y = m_y + 8'd1; set_nz(m_y); end
                8'hCA: begin m_x = m_x - 8'd1; set_nz(m_x); end
                8'h88: begin m_y = m_y - 8'd1; set_nz(m_y); end
                8'hAA: begin m_x = m_a; set_nz(m_x); end
                8'h8A: begin m_a = m_x; set_nz(m_a); end
                8'hA8: begin m_y = m_a; set_nz(m_y); end
                8'h98: begin m_a = m_y; set_nz(m_a); end
                default: ;
            endcase
        end
        m_pc = m_pc + 16'(len);
    endtask

    // Called at a falling edge with the DUT at an opcode fetch.
    task automatic run_insn(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2);
        logic [15:0] ea, last;
        int          exp_cyc, n;
        bit          has_ea;
        mem[m_pc] = op; mem[m_pc + 16'd1] = b1; mem[m_pc + 16'd2] = b2;
        check_val("fetch_addr", 32'(Addr_bus), 32'(m_pc));
        model_step(exp_cyc, ea, has_ea);
        n = 0; last = Addr_bus;
        do begin
            @(posedge clk_ph1);
            @(negedge clk_ph1);
            n++;
            if (cycle_dbg != 3'd0) last = Addr_bus;
        end while (cycle_dbg != 3'd0 && n < 12);
        last_addr_g = last;
        last_cyc_g  = n;
        check_val("cycles", 32'(n), 32'(exp_cyc));
        if (has_ea) check_val("operand_addr", 32'(last), 32'(ea));
        check_val("ir", 32'(IR_dbg), 32'(op));
        check_val("a", 32'(AC_dbg), 32'(m_a));
        check_val("x", 32'(X_dbg), 32'(m_x));
        check_val("y", 32'(Y_dbg), 32'(m_y));
        check_val("p", 32'(P_dbg), 32'(m_p));
        check_val("pc", 32'(PC_dbg), 32'(m_pc));
    endtask

    logic [7:0] ops [19];
    logic [7:0] op_r;

    initial begin
        ops = '{8'h69, 8'h65, 8'h75, 8'h6D, 8'h7D, 8'h79, 8'h61, 8'h71, 8'hE9, 8'h38,
                8'h18, 8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk_ph1);
        @(negedge clk_ph1);
        rst = 1'b0;
        model_reset();
        check_val("rst_addr", 32'(Addr_bus), 32'h0000);
        check_val("rst_pc", 32'(PC_dbg), 32'h0000);
        check_val("rst_cycle", 32'(cycle_dbg), 32'd0);
        check_val("rst_ir", 32'(IR_dbg), 32'h00);
        check_val("rst_a", 32'(AC_dbg), 32'h00);
        check_val("rst_p", 32'(P_dbg), 32'h20);

        for (int i = 0; i < 3; i++) run_insn(8'h00, 8'h00, 8'h00);
        check_val("nop_pc", 32'(PC_dbg), 32'h0003);

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        run_insn(8'hC8, 0, 0); run_insn(8'hC8, 0, 0); run_insn(8'h38, 0, 0);
        check_val("iny_y", 32'(Y_dbg), 32'h02);
        check_val("sec_p", 32'(P_dbg), 32'h21);

        mem[16'h000D] = 8'hFF; mem[16'h000E] = 8'h01; mem[16'h0201] = 8'h07;
        run_insn(8'h71, 8'h0D, 8'h00);
        check_val("izy_ea", 32'(last_addr_g), 32'h0201);
        check_val("izy_a", 32'(AC_dbg), 32'h08);
        check_val("izy_p", 32'(P_dbg), 32'h20);
        check_val("izy_cycles", 32'(last_cyc_g), 32'd6);

        run_insn(8'h38, 0, 0); run_insn(8'hE9, 8'h08, 0);
        run_insn(8'h18, 0, 0); run_insn(8'h69, 8'h7F, 0);
        run_insn(8'h18, 0, 0); run_insn(8'h69, 8'h01, 0);
        check_val("adc_ovf_a", 32'(AC_dbg), 32'h80);
        check_val("adc_ovf_p", 32'(P_dbg), 32'hE0);
        run_insn(8'h38, 0, 0); run_insn(8'hE9, 8'h80, 0);
        check_val("sbc_a", 32'(AC_dbg), 32'h00);
        check_val("sbc_p", 32'(P_dbg), 32'h23);

        run_insn(8'h18, 0, 0); run_insn(8'h69, 8'hFF, 0); run_insn(8'hAA, 0, 0);
        check_val("tax_x", 32'(X_dbg), 32'hFF);
        check_val("tax_n", 32'(P_dbg[7]), 32'd1);
        run_insn(8'hE8, 0, 0);
        check_val("inx_wrap", 32'(X_dbg), 32'h00);
        check_val("inx_z", 32'(P_dbg[1]), 32'd1);
        run_insn(8'h8A, 0, 0); run_insn(8'hA8, 0, 0); run_insn(8'h88, 0, 0);
        check_val("dey_wrap", 32'(Y_dbg), 32'hFF);
        check_val("dey_n", 32'(P_dbg[7]), 32'd1);

        run_insn(8'hE8, 0, 0); run_insn(8'hE8, 0, 0);
        run_insn(8'h75, 8'hFF, 0);
        check_val("zpx_wrap", 32'(last_addr_g), 32'h0001);
        run_insn(8'hCA, 0, 0);
        run_insn(8'h7D, 8'hFF, 8'hFF);
        check_val("abx_wrap", 32'(last_addr_g), 32'h0000);
        check_val("abx_cycles", 32'(last_cyc_g), 32'd5);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) op_r = 8'($urandom);
            else op_r = ops[$urandom_range(18)];
            run_insn(op_r, 8'($urandom), 8'($urandom));
        end

        mem[m_pc] = 8'h61; mem[m_pc + 16'd1] = 8'h40;
        repeat (3) @(posedge clk_ph1);
        @(negedge clk_ph1);
        rst = 1'b1;
        @(posedge clk_ph1);
        @(negedge clk_ph1);
        rst = 1'b0;
        model_reset();
        check_val("abort_addr", 32'(Addr_bus), 32'h0000);
        check_val("abort_cycle", 32'(cycle_dbg), 32'd0);
        check_val("abort_p", 32'(P_dbg), 32'h20);
        run_insn(8'hC8, 0, 0);
        run_insn(8'h69, 8'h11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
